// File: rtl/arbiter_4req_hold.sv
// arbiter_4req_hold: four-requester bus arbiter with multi-cycle grant hold.
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   req[3:0]  - request lines, held high for the whole transaction
//   rr_en     - 0: fixed priority (3>2>1>0), 1: round-robin; used only when arbitrating
//   gnt[3:0]  - registered one-hot grant, zero when idle
//   gnt_id    - index of current grantee, holds last value when idle
//   gnt_valid - high whenever a grant is active
//   timeout   - one-cycle pulse when a grant is preempted by the hold limit
module arbiter_4req_hold #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       rr_en,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]    last_id_q, last_id_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    gnt_id_q, gnt_id_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          timeout_q, timeout_d;

  logic          do_grant;
  logic [3:0]    cand;
  logic [3:0]    others;
  logic          holder_req;
  logic          at_limit;
  logic [1:0]    win;

  // Priority encode over the candidate set. Later loop iterations overwrite
  // earlier ones, so the last match in scan order is the highest priority.
  function automatic logic [1:0] pick_winner(input logic [3:0] c,
                                             input logic       rr,
                                             input logic [1:0] last);
    logic [1:0] w;
    logic [1:0] idx;
    w = '0;
    if (rr) begin
      // Offsets 3..0 from last+1: offset 0 (last+1) is written last and wins.
      for (int unsigned k = 0; k < 4; k++) begin
        idx = last + 2'(3 - k) + 2'd1;
        if (c[idx]) w = idx;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (c[i]) w = 2'(i);
      end
    end
    return w;
  endfunction

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    last_id_d   = last_id_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    do_grant    = 1'b0;
    cand        = '0;

    holder_req = req[gnt_id_q];
    // Other requesters with the current holder masked out.
    others     = req & ~(4'b0001 << gnt_id_q);
    at_limit   = (hold_cnt_q == CW'(MAX_HOLD - 1));

    case (state_q)
      IDLE: begin
        if (|req) begin
          do_grant = 1'b1;
          cand     = req;
        end
      end
      GRANT: begin
        if (!holder_req) begin
          if (|others) begin
            do_grant = 1'b1;
            cand     = others;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
          end
        end else if (!at_limit) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (|others) begin
          do_grant  = 1'b1;
          cand      = others;
          timeout_d = 1'b1;
        end
        // Lone holder at the limit: keep the grant, counter stays saturated.
      end
      default: state_d = IDLE;
    endcase

    win = pick_winner(cand, rr_en, last_id_q);
    if (do_grant) begin
      state_d     = GRANT;
      gnt_d       = 4'b0001 << win;
      gnt_id_d    = win;
      gnt_valid_d = 1'b1;
      last_id_d   = win;
      hold_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      last_id_q   <= 2'd3;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      last_id_q   <= last_id_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_arbiter_4req_hold.sv
// Testbench for arbiter_4req_hold: directed per-cycle vectors with expected
// outputs pushed into a scoreboard queue, checked by an independent monitor.
module tb_arbiter_4req_hold;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       rr_en = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       to;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  arbiter_4req_hold #(.MAX_HOLD(8), .CW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .rr_en    (rr_en),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  task automatic chk(input string name, input string field,
                     input logic [3:0] act, input logic [3:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %b expected %b at %0t", name, field, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs; the expectation describes outputs after the edge.
  task automatic cyc(input string name, input logic r, input logic [3:0] rq,
                     input logic rr, input logic [3:0] eg, input logic [1:0] eid,
                     input logic eto);
    exp_t e;
    @(negedge clk);
    rst   = r;
    req   = rq;
    rr_en = rr;
    @(posedge clk);
    #1;
    e.name = name;
    e.gnt  = eg;
    e.id   = eid;
    e.to   = eto;
    sb_q.push_back(e);
  endtask

  task automatic cycn(input string name, input logic r, input logic [3:0] rq,
                      input logic rr, input logic [3:0] eg, input logic [1:0] eid,
                      input logic eto, input int n);
    for (int i = 0; i < n; i++) cyc(name, r, rq, rr, eg, eid, eto);
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk(e.name, "gnt",       gnt,             e.gnt);
        chk(e.name, "gnt_id",    {2'b00, gnt_id}, {2'b00, e.id});
        chk(e.name, "gnt_valid", {3'b000, gnt_valid}, {3'b000, |e.gnt});
        chk(e.name, "timeout",   {3'b000, timeout},   {3'b000, e.to});
      end
    end
  end

  initial begin
    // 1. reset with requests pending, then idle
    cycn("rst_hold", 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 2);
    cycn("idle",     1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2);

    // 2. fixed priority from idle
    cyc ("fix_0110", 1'b0, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b0);
    cyc ("fix_rel1", 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);
    cyc ("fix_idl1", 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);
    cyc ("fix_1011", 1'b0, 4'b1011, 1'b0, 4'b1000, 2'd3, 1'b0);
    cyc ("fix_rel2", 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0);
    cyc ("fix_1111", 1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0);
    cyc ("fix_rel3", 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0);

    // 3. round-robin rotation after reset, back-to-back handovers
    cyc ("rr_rst",   1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    cyc ("rr_g0",    1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0);
    cyc ("rr_h0",    1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0);
    cyc ("rr_g1",    1'b0, 4'b1110, 1'b1, 4'b0010, 2'd1, 1'b0);
    cyc ("rr_h1",    1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b0);
    cyc ("rr_g2",    1'b0, 4'b1101, 1'b1, 4'b0100, 2'd2, 1'b0);
    cyc ("rr_h2",    1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b0);
    cyc ("rr_g3",    1'b0, 4'b1011, 1'b1, 4'b1000, 2'd3, 1'b0);
    cyc ("rr_h3",    1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b0);
    cyc ("rr_g0b",   1'b0, 4'b0111, 1'b1, 4'b0001, 2'd0, 1'b0);
    cyc ("rr_idle",  1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);

    // 4. hold timeout: holder 0 gets exactly 8 cycles, then preempted
    cyc ("to_g0",    1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    cycn("to_hold0", 1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0, 7);
    cyc ("to_fire",  1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1);
    cyc ("to_h1a",   1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0);
    cycn("to_h1b",   1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, 2);
    cyc ("to_idle",  1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);

    // 5. lone holder saturates, then preempted as soon as another requests
    cycn("sat_hold", 1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, 20);
    cyc ("sat_fire", 1'b0, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1);
    cyc ("sat_h0",   1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc ("sat_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // 6. mid-transaction reset; round-robin restart shows last_id back at 3
    cyc ("mr_g3",    1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0);
    cyc ("mr_h3",    1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0);
    cyc ("mr_rst",   1'b1, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0);
    cyc ("mr_rr0",   1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0);
    cyc ("mr_idl",   1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    cyc ("mr_g1",    1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b0);
    cyc ("mr_rst1",  1'b1, 4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0);
    cyc ("mr_rr0b",  1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0);
    cyc ("mr_idl2",  1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    // release to idle with nothing else pending
    cyc ("rel_g2",   1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    cyc ("rel_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbiter_4req_hold.md
Name: arbiter_4req_hold

Overview:
- Four-requester bus arbiter built around a 4-to-2 priority-encode function.
- Shares one downstream resource among requesters 0..3 and issues a registered one-hot grant plus an encoded grant index.
- Supports two arbitration modes:
  - fixed priority: req[3] highest, matching the team's priority-encoder convention;
  - round-robin.
- Grants are held for a multi-cycle transaction, with a hold-timeout that prevents starvation.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles before forced re-arbitration when another requester is waiting. Legal range is 2..255.
- CW, 8: width of the hold counter. Must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  4  request lines; req[i] stays high for the whole transaction.
- rr_en  input  1  0 = fixed priority (3>2>1>0); 1 = round-robin. Sampled only at arbitration points.
- gnt  output  4  registered one-hot grant; all zeros when idle.
- gnt_id  output  2  index of the current grantee; holds its last value when idle.
- gnt_valid  output  1  high when any gnt bit is high.
- timeout  output  1  one-cycle pulse on the cycle a grant is preempted by the hold-timeout.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - Reset values: gnt=0000, gnt_id=00, gnt_valid=0, timeout=0, state=IDLE, hold_cnt=0, last_id=3.
  - Because last_id resets to 3, round-robin starts with req[0] as highest priority.
- States: IDLE and GRANT.
- Arbitration point: any rising edge where state=IDLE, or state=GRANT and the grant is being released or preempted.
  - Fixed mode: the highest-index asserted candidate wins.
  - Round-robin mode: candidates are scanned from (last_id+1) mod 4 upward with wrap-around; the first asserted one wins.
  - The winner is registered on that edge, so grant latency is 1 cycle from req sampled high to gnt high.
  - On every grant: last_id <= winner and hold_cnt <= 0.
- IDLE:
  - req=0000: stay in IDLE, outputs remain idle.
  - Otherwise: arbitrate and move to GRANT.
- GRANT, holder = gnt_id:
  - Release: req[holder]=0 at an edge.
    - If any other req is high, re-arbitrate on the same edge; the new gnt appears on the next cycle with no idle bubble.
    - Otherwise gnt <= 0000, gnt_valid <= 0, go to IDLE.
  - Hold: req[holder]=1 and hold_cnt < MAX_HOLD-1.
    - Keep the grant; hold_cnt increments.
  - Timeout: req[holder]=1, hold_cnt == MAX_HOLD-1, and another req is high.
    - Re-arbitrate with the holder masked out in both modes; the new grant is registered.
    - timeout=1 for exactly that next cycle.
    - The old holder may win again only at a later arbitration point.
  - Lone holder at limit: req[holder]=1, hold_cnt == MAX_HOLD-1, and no other req.
    - Keep the grant; hold_cnt saturates at MAX_HOLD-1.
    - A timeout fires as soon as another req appears, so the grant changes on the next edge.
- gnt_valid is identical to |gnt. gnt is never multi-hot.
- A change of rr_en mid-grant has no effect until the next arbitration point.
- Reset asserted in any state, mid-transaction included: the next edge forces the reset values regardless of req.
- Requests that drop before being granted are simply not considered; there is no request latching.

Test Plan:
1. Reset and idle: rst=1 for 2 cycles with req=1111, then rst=0 and req=0000.
   - gnt=0000, gnt_valid=0, gnt_id=00 throughout.
2. Fixed priority, rr_en=0: apply req=0110, later 1011, later 1111, one fresh request each time from IDLE.
   - Winners are gnt=0100/id=10, gnt=1000/id=11, gnt=1000/id=11.
   - Each grant appears 1 cycle after req.
3. Round-robin rotation, rr_en=1: after reset, hold req=1111 and have each holder drop its req 2 cycles after being granted, then reassert it.
   - Grant sequence is id 0, 1, 2, 3, 0.
   - No idle cycle between grants.
4. Hold timeout, MAX_HOLD=8, rr_en=0: req=0001 granted, then req=0011 raised while holder 0 stays high.
   - Holder 0 is granted for 8 consecutive cycles.
   - The next cycle shows gnt=0010 with timeout=1 for 1 cycle.
   - Holder 1 then keeps the grant while its req stays high.
5. Lone holder saturation: req=0100 held for 20 cycles.
   - gnt=0100 for the full 20 cycles with timeout=0.
   - Raising req[0] then gives gnt=0001 and timeout=1 on the next cycle.
6. Mid-transaction reset and release-to-idle: assert rst while gnt=1000.
   - Next cycle gnt=0000 and last_id=3.
   - Separately: holder drops req with no other request pending, giving gnt=0000 and gnt_valid=0 on the next cycle.
